// File: rtl/mojo_com_logic.sv
// Serial command bridge: decodes header/address bytes from the UART core and
// moves bytes between the serial link and a 256-byte register space.
module mojo_com_logic (
    input  logic          clk,
    input  logic          rst,
    output logic [7:0]    ser_tx_data,
    output logic          ser_new_tx_data,
    input  logic          ser_tx_busy,
    input  logic [7:0]    ser_rx_data,
    input  logic          ser_new_rx_data,
    output logic [2047:0] rx_arr,
    output logic          rx_busy,
    output logic          new_rx,
    input  logic [2047:0] tx_arr,
    output logic          tx_busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned IDX_W  = 11;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              dir_q, dir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hold_q, hold_d;
    logic [BYTE_W-1:0] tx_data_d;
    logic              tx_new_d;
    logic              new_rx_d;
    logic              rx_busy_d;
    logic              tx_busy_d;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [BYTE_W-1:0] rd_byte;

    // In ADDR the first read byte is fetched straight from the incoming address
    assign rd_addr = (state_q == ADDR) ? ser_rx_data : addr_q;
    assign rd_byte = tx_arr[{rd_addr, 3'b000} +: BYTE_W];

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        tx_data_d = ser_tx_data;
        tx_new_d  = 1'b0;
        new_rx_d  = 1'b0;
        wr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ser_new_rx_data) begin
                    dir_d   = ser_rx_data[7];
                    cnt_d   = ser_rx_data[6:0];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ser_new_rx_data) begin
                    addr_d = ser_rx_data;
                    if (cnt_q == CNT_W'(0)) begin
                        state_d = IDLE;
                    end else if (dir_q) begin
                        state_d = WRITE;
                    end else if (!ser_tx_busy) begin
                        tx_data_d = rd_byte;
                        tx_new_d  = 1'b1;
                        hold_d    = 1'b1;
                        state_d   = WAIT;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            WRITE: begin
                if (ser_new_rx_data) begin
                    wr_en  = 1'b1;
                    addr_d = ADDR_W'(addr_q + ADDR_W'(1));
                    cnt_d  = CNT_W'(cnt_q - CNT_W'(1));
                    if (cnt_q == CNT_W'(1)) begin
                        new_rx_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            SEND: begin
                if (!ser_tx_busy) begin
                    tx_data_d = rd_byte;
                    tx_new_d  = 1'b1;
                    hold_d    = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // First WAIT cycle lets the transmitter react to the strobe
                if (hold_q) begin
                    hold_d = 1'b0;
                end else if (!ser_tx_busy) begin
                    addr_d  = ADDR_W'(addr_q + ADDR_W'(1));
                    cnt_d   = CNT_W'(cnt_q - CNT_W'(1));
                    state_d = (cnt_q == CNT_W'(1)) ? IDLE : SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rx_busy_d = ((state_d == ADDR) && dir_d) || (state_d == WRITE);
        tx_busy_d = ((state_d == ADDR) && !dir_d) || (state_d == SEND) || (state_d == WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            dir_q           <= 1'b0;
            cnt_q           <= '0;
            addr_q          <= '0;
            hold_q          <= 1'b0;
            ser_tx_data     <= '0;
            ser_new_tx_data <= 1'b0;
            new_rx          <= 1'b0;
            rx_busy         <= 1'b0;
            tx_busy         <= 1'b0;
            rx_arr          <= '0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            hold_q          <= hold_d;
            ser_tx_data     <= tx_data_d;
            ser_new_tx_data <= tx_new_d;
            new_rx          <= new_rx_d;
            rx_busy         <= rx_busy_d;
            tx_busy         <= tx_busy_d;
            if (wr_en) begin
                rx_arr[{addr_q, 3'b000} +: BYTE_W] <= ser_rx_data;
            end
        end
    end

endmodule

// File: tb/tb_mojo_com_logic.sv
// Randomized self-checking bench for mojo_com_logic against a byte-array model.
module tb_mojo_com_logic;

    logic          clk;
    logic          rst;
    logic [7:0]    ser_tx_data;
    logic          ser_new_tx_data;
    logic          ser_tx_busy;
    logic [7:0]    ser_rx_data;
    logic          ser_new_rx_data;
    logic [2047:0] rx_arr;
    logic          rx_busy;
    logic          new_rx;
    logic [2047:0] tx_arr;
    logic          tx_busy;

    mojo_com_logic dut (
        .clk             (clk),
        .rst             (rst),
        .ser_tx_data     (ser_tx_data),
        .ser_new_tx_data (ser_new_tx_data),
        .ser_tx_busy     (ser_tx_busy),
        .ser_rx_data     (ser_rx_data),
        .ser_new_rx_data (ser_new_rx_data),
        .rx_arr          (rx_arr),
        .rx_busy         (rx_busy),
        .new_rx          (new_rx),
        .tx_arr          (tx_arr),
        .tx_busy         (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_rx [256];
    logic [7:0] tx_mem [256];
    logic [7:0] wdata [$];
    logic [7:0] strobe_q [$];
    int         busy_len = 0;
    int         busy_cnt = 0;
    int         new_rx_cnt = 0;
    logic       prev_strobe = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2047:0] exp_rx();
        logic [2047:0] v;
        for (int i = 0; i < 256; i++) v[i*8 +: 8] = ref_rx[i];
        return v;
    endfunction

    task automatic load_tx();
        for (int i = 0; i < 256; i++) tx_arr[i*8 +: 8] = tx_mem[i];
    endtask

    // Transmitter model: captures strobes and holds busy for busy_len cycles
    always @(negedge clk) begin
        if (new_rx) new_rx_cnt++;
        if (ser_new_tx_data) begin
            strobe_q.push_back(ser_tx_data);
            check("strobe_while_busy", 32'(ser_tx_busy), 32'd0);
            check("strobe_width", 32'(prev_strobe), 32'd0);
            if (busy_len > 0) begin
                ser_tx_busy = 1'b1;
                busy_cnt    = busy_len;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) ser_tx_busy = 1'b0;
        end
        prev_strobe = ser_new_tx_data;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        ser_rx_data     = b;
        ser_new_rx_data = 1'b1;
        @(negedge clk);
        ser_new_rx_data = 1'b0;
    endtask

    task automatic do_write(input int a, input int n, input int gap);
        int c0;
        logic [7:0] b;
        c0 = new_rx_cnt;
        send_byte({1'b1, 7'(n)}, gap);
        check("wr_hdr_rx_busy", 32'(rx_busy), 32'd1);
        check("wr_hdr_tx_busy", 32'(tx_busy), 32'd0);
        send_byte(8'(a), gap);
        check("wr_addr_rx_busy", 32'(rx_busy), (n > 0) ? 32'd1 : 32'd0);
        for (int k = 0; k < n; k++) begin
            b = wdata.pop_front();
            ref_rx[(a + k) % 256] = b;
            send_byte(b, gap);
            if (k < n - 1) check("wr_mid_new_rx", 32'(new_rx), 32'd0);
        end
        if (n > 0) begin
            check("wr_done_new_rx", 32'(new_rx), 32'd1);
            check("wr_done_rx_busy", 32'(rx_busy), 32'd0);
        end
        @(negedge clk);
        check("wr_new_rx_width", 32'(new_rx), 32'd0);
        repeat (2) @(negedge clk);
        check("wr_pulses", 32'(new_rx_cnt - c0), (n > 0) ? 32'd1 : 32'd0);
        check("wr_rx_arr", 32'(rx_arr == exp_rx()), 32'd1);
    endtask

    task automatic do_read(input int a, input int n, input int blen, input int gap);
        int c0;
        int cyc;
        cyc = 0;
        while (busy_cnt > 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        busy_len = blen;
        strobe_q.delete();
        c0 = new_rx_cnt;
        send_byte({1'b0, 7'(n)}, gap);
        check("rd_hdr_tx_busy", 32'(tx_busy), 32'd1);
        check("rd_hdr_rx_busy", 32'(rx_busy), 32'd0);
        send_byte(8'(a), gap);
        if (n > 0) check("rd_first_strobe", 32'(ser_new_tx_data), 32'd1);
        cyc = 0;
        // Junk rx strobes while the read is running must be ignored
        while (tx_busy && cyc < 3000) begin
            ser_rx_data     = 8'($urandom);
            ser_new_rx_data = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            cyc++;
        end
        ser_new_rx_data = 1'b0;
        check("rd_timeout", 32'(cyc < 3000), 32'd1);
        repeat (2) @(negedge clk);
        check("rd_count", 32'(strobe_q.size()), 32'(n));
        for (int k = 0; k < n && k < strobe_q.size(); k++)
            check("rd_data", 32'(strobe_q[k]), 32'(tx_mem[(a + k) % 256]));
        if (n > 0 && strobe_q.size() == n)
            check("rd_hold", 32'(ser_tx_data), 32'(strobe_q[n-1]));
        check("rd_no_new_rx", 32'(new_rx_cnt - c0), 32'd0);
        check("rd_tx_busy_end", 32'(tx_busy), 32'd0);
        check("rd_rx_arr", 32'(rx_arr == exp_rx()), 32'd1);
    endtask

    initial begin
        rst             = 1'b0;
        ser_tx_busy     = 1'b0;
        ser_rx_data     = 8'h00;
        ser_new_rx_data = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_rx[i] = 8'h00;
            tx_mem[i] = 8'h00;
        end
        tx_mem[0] = 8'hef;
        tx_mem[1] = 8'hbe;
        tx_mem[2] = 8'had;
        tx_mem[3] = 8'hde;
        load_tx();
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({ser_tx_data, ser_new_tx_data, new_rx, rx_busy, tx_busy}), 32'd0);
        check("rst_rx_arr", 32'(rx_arr == '0), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        wdata.push_back(8'h06);
        do_write(2, 1, 100);
        do_read(3, 1, 0, 2);
        do_read(0, 4, 5, 1);
        wdata.push_back(8'h11);
        wdata.push_back(8'h22);
        do_write(255, 2, 1);
        check("wrap_hi", 32'(rx_arr[2047:2040]), 32'h11);
        check("wrap_lo", 32'(rx_arr[7:0]), 32'h22);
        do_write(5, 0, 1);
        wdata.push_back(8'h33);
        do_write(5, 1, 0);
        check("byte5", 32'(rx_arr[47:40]), 32'h33);

        // Abort a write mid-transaction with an asynchronous reset
        send_byte(8'h82, 1);
        send_byte(8'h00, 1);
        send_byte(8'hAA, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_outputs", 32'({ser_tx_data, ser_new_tx_data, new_rx, rx_busy, tx_busy}), 32'd0);
        check("abort_rx_arr", 32'(rx_arr == '0), 32'd1);
        for (int i = 0; i < 256; i++) ref_rx[i] = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wdata.push_back(8'h44);
        do_write(7, 1, 0);

        for (int i = 0; i < 256; i++) tx_mem[i] = 8'($urandom);
        load_tx();
        for (int t = 0; t < 40; t++) begin
            int a;
            int n;
            a = $urandom_range(0, 255);
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) wdata.push_back(8'($urandom));
                do_write(a, n, $urandom_range(0, 3));
            end else begin
                do_read(a, n, $urandom_range(0, 4), $urandom_range(0, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
